bm_memory_scan_reader: RTL and testbench
========================================

# bm_memory_scan_reader

Read-side companion to the team's simple synchronous word memory: on a start pulse it walks a contiguous, wrap-around address range of the memory, issues one read per word, and streams the returned words downstream over a valid/ready handshake. It sits between a `WORD_SIZE`-wide, `2**BITS`-deep memory with a registered read port and any consumer that can stall. Backpressure is absorbed by an internal 4-entry buffer, so no returned word is ever dropped.

## Interface
- `BITS`, 2, address width; memory depth `DEPTH = 2**BITS`
- `WORD_SIZE`, 4, data word width
- `clock` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-low; sampled only on the rising edge of `clock`.
- `start` in 1: begin a scan; honoured only in IDLE.
- `start_addr` in `BITS`: first address of the scan.
- `count` in `BITS+1`: number of words to read.
- `mem_addr` out `BITS`: registered memory read address.
- `mem_rd_en` out 1: registered read strobe.
- `mem_rdata` in `WORD_SIZE`: read data, valid the cycle after `mem_rd_en`.
- `value_out` out `WORD_SIZE`: streamed word (head of buffer).
- `value_valid` out 1: `value_out` is valid.
- `value_ready` in 1: consumer accepts; transfer when `value_valid & value_ready`.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan completion.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: `start=1` latches `start_addr` and `min(count, DEPTH)`, then moves to READ. If `count=0`, stays in IDLE, pulses `done` next cycle, issues no reads.
- READ: issues one read per cycle while the credit rule holds. Credit rule: buffer occupancy + reads outstanding (issued, data not yet written to the buffer) < 4.
- Address increments modulo `DEPTH`: start 3, count 3 reads 3, 0, 1.
- Moves to DRAIN after the last read is issued.
- DRAIN: waits until every outstanding read has landed and the buffer has emptied via handshakes. It then pulses `done` and returns to IDLE.
- Buffer: 4-entry FIFO written from `mem_rdata` the cycle after each `mem_rd_en`. Output order equals address order.
- `value_out` holds its value while `value_valid=1` and `value_ready=0`.
- `start` is ignored in READ and DRAIN, including the `done` cycle.
- Reset at any point: FSM goes to IDLE, buffer is flushed, outstanding reads are discarded (returning `mem_rdata` is not written), and no `done` pulse is produced.

## Timing
- Reset values: `mem_addr=0`, `mem_rd_en=0`, `value_out=0`, `value_valid=0`, `busy=0`, `done=0`.
- Start sampled in cycle T:
  - `busy=1` and first `mem_rd_en` in T+1.
  - First word in the buffer at the T+2 edge; `value_valid=1` in T+3.
- With `value_ready` held high, one word per cycle: the N-th word is valid in T+2+N.
- `done` is asserted the cycle after the final handshake, and `busy` falls together with `done`. With `count=0`, `done` is asserted in T+1 and `busy` stays 0.
- `mem_rd_en` deasserts within the cycle after the buffer reaches 4 committed entries (occupancy + outstanding). Reads resume the cycle after a handshake frees credit.

## Configuration
- `MEM_READER_PARITY_EN` defined:
  - Adds output `value_parity` (1 bit): even parity (XOR) of `value_out`.
  - Buffer width becomes `WORD_SIZE+1`.
  - Parity is computed on the write into the buffer.
  - `value_parity` resets to 0.
- `MEM_READER_PARITY_EN` undefined: the port and the extra storage are absent; behaviour is otherwise identical.

## Structure
- Package `bm_mem_reader_pkg`:
  - FSM state encoding (IDLE=0, READ=1, DRAIN=2).
  - Buffer depth constant 4.
  - Credit width.
- Sub-module `bm_mem_reader_fifo`: 4-entry synchronous FIFO with push/pop, occupancy, and registered head output. The top level holds the FSM, address counter, remaining-count counter and outstanding counter.

## Test plan
- Memory preloaded 0:A, 1:5, 2:C, 3:3, `value_ready=1`, start 0, count 4 → `value_out` A, 5, C, 3 in T+3..T+6; `done` in T+7.
- Start 3, count 3 → `mem_addr` 3, 0, 1; outputs 3, A, 5.
- `value_ready=0` for 10 cycles after start, count 4 → reads stop after 4 commitments. After release, all 4 words appear in order, none lost or duplicated.
- `count=0` → `done` in T+1, no `mem_rd_en`. `count=7` → exactly 4 words.
- `reset` driven low mid-READ with 2 outstanding reads → all outputs at reset values next cycle, no stale words after restart. A second `start` while busy is ignored.
- `MEM_READER_PARITY_EN` defined → for word C, `value_parity=0`; for word 7, `value_parity=1`.

Source files
------------

// File: rtl/bm_mem_reader_pkg.sv
// Shared types and sizing constants for the memory scan reader.
// Build option MEM_READER_PARITY_EN (used by the top level) widens the buffer by a parity bit.
package bm_mem_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 4;
    localparam int PTR_W     = 2;
    localparam int CREDIT_W  = 3;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 3'd4;

endpackage

// File: rtl/bm_mem_reader_fifo.sv
// Four-entry synchronous FIFO that holds returned words until the consumer takes them.
// The head is read straight from the storage registers; occupancy feeds the read-credit check.
module bm_mem_reader_fifo
    import bm_mem_reader_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_push,
    input  logic [WIDTH-1:0]    i_wdata,
    input  logic                i_pop,
    output logic [WIDTH-1:0]    o_head,
    output logic                o_head_valid,
    output logic [CREDIT_W-1:0] o_occupancy
);

    logic [WIDTH-1:0]    r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CREDIT_W-1:0] r_count;
    logic                w_pop;

    assign w_pop        = i_pop && (r_count != 3'd0);
    assign o_head       = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != 3'd0);
    assign o_occupancy  = r_count;

    // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, i_push} - {2'b00, w_pop};
        end
    end

endmodule

// File: rtl/bm_memory_scan_reader.sv
// Walks a wrap-around address range of a registered-read memory and streams the words out.
// Optional build macro MEM_READER_PARITY_EN adds an even-parity bit alongside value_out.
module bm_memory_scan_reader
    import bm_mem_reader_pkg::*;
#(
    parameter int BITS      = 2,
    parameter int WORD_SIZE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS-1:0]      start_addr,
    input  logic [BITS:0]        count,
    output logic [BITS-1:0]      mem_addr,
    output logic                 mem_rd_en,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] value_out,
    output logic                 value_valid,
    input  logic                 value_ready,
    output logic                 busy,
`ifdef MEM_READER_PARITY_EN
    output logic                 value_parity,
`endif
    output logic                 done
);

    localparam logic [BITS:0] DEPTH_C = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0] ONE_C   = (BITS+1)'(1);
`ifdef MEM_READER_PARITY_EN
    localparam int BUF_W = WORD_SIZE + 1;

    function automatic logic f_even_parity(input logic [WORD_SIZE-1:0] word);
        return ^word;
    endfunction
`else
    localparam int BUF_W = WORD_SIZE;
`endif

    state_t              r_state;
    logic [BITS-1:0]     r_mem_addr;
    logic                r_rd_en;
    logic                r_land;
    logic                r_busy;
    logic                r_done;
    logic [BITS:0]       r_remaining;
    logic [CREDIT_W-1:0] r_outstanding;

    logic                w_pop;
    logic [CREDIT_W-1:0] w_occupancy;
    logic [CREDIT_W-1:0] w_after_pop;
    logic                w_credit_ok;
    logic [BITS:0]       w_len;
    logic                w_start_ok;
    logic                w_issue;
    logic [BUF_W-1:0]    w_buf_wdata;
    logic [BUF_W-1:0]    w_buf_head;

`ifdef MEM_READER_PARITY_EN
    assign w_buf_wdata  = {f_even_parity(mem_rdata), mem_rdata};
    assign value_parity = w_buf_head[WORD_SIZE];
`else
    assign w_buf_wdata  = mem_rdata;
`endif
    assign value_out = w_buf_head[WORD_SIZE-1:0];
    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_rd_en;
    assign busy      = r_busy;
    assign done      = r_done;

    bm_mem_reader_fifo #(.WIDTH(BUF_W)) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_push       (r_land),
        .i_wdata      (w_buf_wdata),
        .i_pop        (w_pop),
        .o_head       (w_buf_head),
        .o_head_valid (value_valid),
        .o_occupancy  (w_occupancy)
    );

    // Credit counts buffered plus in-flight words, after this cycle's handshake frees a slot.
    always_comb begin
        w_pop       = value_valid & value_ready;
        w_after_pop = w_occupancy + r_outstanding - {2'b00, w_pop};
        w_credit_ok = (w_after_pop < CREDIT_MAX);
        w_len       = (count > DEPTH_C) ? DEPTH_C : count;
        w_start_ok  = (r_state == ST_IDLE) && start && !r_done;
        case (r_state)
            ST_IDLE: w_issue = w_start_ok && (count != '0);
            ST_READ: w_issue = w_credit_ok;
            default: w_issue = 1'b0;
        endcase
    end

    // Scan FSM with address, remaining-count and outstanding-read tracking.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_mem_addr    <= '0;
            r_rd_en       <= 1'b0;
            r_land        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_remaining   <= '0;
            r_outstanding <= 3'd0;
        end else begin
            r_land        <= r_rd_en;
            r_rd_en       <= w_issue;
            r_outstanding <= r_outstanding + {2'b00, w_issue} - {2'b00, r_land};
            r_done        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_mem_addr  <= start_addr;
                            r_remaining <= w_len - ONE_C;
                            r_busy      <= 1'b1;
                            r_state     <= (w_len == ONE_C) ? ST_DRAIN : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_credit_ok) begin
                        r_mem_addr  <= r_mem_addr + BITS'(1);
                        r_remaining <= r_remaining - ONE_C;
                        if (r_remaining == ONE_C) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_after_pop == 3'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bm_memory_scan_reader.sv
// Directed self-checking bench for bm_memory_scan_reader with a scoreboard of expected words.
// Build with MEM_READER_PARITY_EN defined to also check value_parity.
module tb_bm_memory_scan_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] start_addr = 2'd0;
    logic [2:0] count = 3'd0;
    logic [1:0] mem_addr;
    logic       mem_rd_en;
    logic [3:0] mem_rdata = 4'h0;
    logic [3:0] value_out;
    logic       value_valid;
    logic       value_ready = 1'b0;
    logic       busy;
    logic       done;
`ifdef MEM_READER_PARITY_EN
    logic       value_parity;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         rd_cnt = 0;
    int         base;
    logic [3:0] tbmem [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
    logic [3:0] exp_q [$];

    bm_memory_scan_reader #(.BITS(2), .WORD_SIZE(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .count       (count),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .value_out   (value_out),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
`ifdef MEM_READER_PARITY_EN
        .value_parity(value_parity),
`endif
        .done        (done)
    );

    always #5 clock = ~clock;

    // Registered-read memory model and read-strobe counter.
    always @(posedge clock) begin
        if (mem_rd_en) begin
            mem_rdata <= tbmem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scores this cycle's handshake (inputs are final), then advances to the next negedge.
    task automatic step();
        logic [3:0] w;
        if (value_valid && value_ready) begin
            check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("word", {28'd0, value_out}, {28'd0, w});
`ifdef MEM_READER_PARITY_EN
                check("parity", {31'd0, value_parity}, {31'd0, ^w});
`endif
            end
        end
        @(negedge clock);
    endtask

    task automatic start_scan(input logic [1:0] sa, input logic [2:0] cnt);
        logic [1:0] a;
        int         n;
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        n          = (cnt > 3'd4) ? 4 : int'(cnt);
        a          = sa;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(tbmem[a]);
            a = a + 2'd1;
        end
    endtask

    task automatic wait_done(input string tag, input int max);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  {30'd0, mem_addr}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        check({tag, "_value"}, {28'd0, value_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, value_valid}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
`ifdef MEM_READER_PARITY_EN
        check({tag, "_parity"}, {31'd0, value_parity}, 32'd0);
`endif
    endtask

    initial begin
        @(negedge clock);
        step();
        step();
        check_reset_values("rst");
        reset = 1'b1;
        step();

        // Full scan from 0 with the consumer always ready.
        value_ready = 1'b1;
        start_scan(2'd0, 3'd4);
        step();
        start = 1'b0;
        check("t1_busy_T1", {31'd0, busy}, 32'd1);
        check("t1_rd_en_T1", {31'd0, mem_rd_en}, 32'd1);
        check("t1_addr_T1", {30'd0, mem_addr}, 32'd0);
        step();
        check("t1_valid_T2", {31'd0, value_valid}, 32'd0);
        check("t1_addr_T2", {30'd0, mem_addr}, 32'd1);
        step();
        check("t1_valid_T3", {31'd0, value_valid}, 32'd1);
        check("t1_value_T3", {28'd0, value_out}, 32'hA);
        step();
        step();
        step();
        check("t1_done_T6", {31'd0, done}, 32'd0);
        step();
        check("t1_done_T7", {31'd0, done}, 32'd1);
        check("t1_busy_T7", {31'd0, busy}, 32'd0);
        step();
        check("t1_done_T8", {31'd0, done}, 32'd0);
        check("t1_drained", exp_q.size(), 32'd0);

        // Wrap-around scan; a second start while busy must be ignored.
        base = rd_cnt;
        start_scan(2'd3, 3'd3);
        step();
        start = 1'b0;
        check("t2_addr_T1", {30'd0, mem_addr}, 32'd3);
        start      = 1'b1;
        start_addr = 2'd0;
        count      = 3'd4;
        step();
        start = 1'b0;
        check("t2_addr_T2", {30'd0, mem_addr}, 32'd0);
        step();
        check("t2_addr_T3", {30'd0, mem_addr}, 32'd1);
        wait_done("t2_done", 30);
        step();
        check("t2_reads", rd_cnt - base, 32'd3);
        check("t2_drained", exp_q.size(), 32'd0);

        // Consumer stalled for 10 cycles, then released.
        value_ready = 1'b0;
        base = rd_cnt;
        start_scan(2'd1, 3'd4);
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t3_reads_stalled", rd_cnt - base, 32'd4);
        check("t3_rd_en_stalled", {31'd0, mem_rd_en}, 32'd0);
        check("t3_valid_held", {31'd0, value_valid}, 32'd1);
        check("t3_value_held", {28'd0, value_out}, 32'h5);
        check("t3_busy_stalled", {31'd0, busy}, 32'd1);
        value_ready = 1'b1;
        wait_done("t3_done", 30);
        step();
        check("t3_drained", exp_q.size(), 32'd0);

        // count=0 gives an immediate done with no reads.
        base = rd_cnt;
        start_scan(2'd0, 3'd0);
        step();
        start = 1'b0;
        check("t4_done_T1", {31'd0, done}, 32'd1);
        check("t4_busy_T1", {31'd0, busy}, 32'd0);
        check("t4_rd_en_T1", {31'd0, mem_rd_en}, 32'd0);
        step();
        check("t4_done_T2", {31'd0, done}, 32'd0);
        check("t4_reads", rd_cnt - base, 32'd0);

        // count=7 is clamped to the depth; start in the done cycle is ignored.
        base = rd_cnt;
        start_scan(2'd2, 3'd7);
        step();
        start = 1'b0;
        wait_done("t5_done", 30);
        check("t5_reads", rd_cnt - base, 32'd4);
        start      = 1'b1;
        start_addr = 2'd0;
        count      = 3'd2;
        step();
        start = 1'b0;
        check("t5_busy_after_done", {31'd0, busy}, 32'd0);
        check("t5_rd_en_after_done", {31'd0, mem_rd_en}, 32'd0);
        step();
        check("t5_drained", exp_q.size(), 32'd0);

        // Reset mid-read with two reads in flight.
        value_ready = 1'b0;
        start_scan(2'd0, 3'd4);
        step();
        start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_values("t6_rst");
        exp_q.delete();
        value_ready = 1'b1;
        step();
        step();
        step();
        check("t6_no_stale", {31'd0, value_valid}, 32'd0);
        start_scan(2'd2, 3'd2);
        step();
        start = 1'b0;
        wait_done("t6_done", 30);
        step();
        check("t6_drained", exp_q.size(), 32'd0);

        // A word with odd bit count (7) exercises a set parity bit.
        tbmem[1] = 4'h7;
        start_scan(2'd1, 3'd1);
        step();
        start = 1'b0;
        wait_done("t7_done", 30);
        step();
        check("t7_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
